fifo_drain_ctrl: RTL and testbench



---
 rtl/fifo_wdelay_pkg.sv | 20 ++
 rtl/drain_skid_buf.sv | 87 ++++++++
 rtl/fifo_drain_ctrl.sv | 98 +++++++++
 tb/tb_fifo_drain_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wdelay_pkg.sv
// ============================================================================
// Module   : fifo_wdelay_pkg
// Brief    : Shared constants and helpers for the delayed-FIFO read path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wdelay_pkg;

   localparam int DEFAULT_DATA_WIDTH = 4;
   localparam int FIFO_READ_LATENCY  = 5;

   // Bits needed to hold a count in the closed range 0..n.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/drain_skid_buf.sv
// ============================================================================
// Module   : drain_skid_buf
// Brief    : Circular capture buffer with occupancy and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_skid_buf
   import fifo_wdelay_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = 8
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_wr,
   input  logic [DATA_WIDTH-1:0]          i_wr_data,
   input  logic                           i_rd_ready,
   output logic                           o_valid,
   output logic [DATA_WIDTH-1:0]          o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     o_occupancy,
   output logic                           o_overflow
);

   localparam int             PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CW     = count_width(DEPTH);
   localparam logic [PW-1:0]  C_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_occ;
   logic                  r_overflow;

   logic                  w_pop;
   logic                  w_full;
   logic                  w_push;
   logic [PW-1:0]         w_wr_next;
   logic [PW-1:0]         w_rd_next;

   assign w_pop  = (r_occ != '0) && i_rd_ready;
   assign w_full = (r_occ == C_FULL);
   // A full buffer can still accept a capture when the head leaves this cycle.
   assign w_push = i_wr && (!w_full || w_pop);

   assign w_wr_next = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_next = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= w_wr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + CW'(1);
            2'b01:   r_occ <= r_occ - CW'(1);
            default: r_occ <= r_occ;
         endcase
         if (i_wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_valid     = (r_occ != '0);
   assign o_rd_data   = r_mem[r_rd_ptr];
   assign o_occupancy = r_occ;
   assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
// ============================================================================
// Module   : fifo_drain_ctrl
// Brief    : Credit-gated read controller turning a fixed-latency FIFO read
//            port into a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain_ctrl
   import fifo_wdelay_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int READ_LATENCY = FIFO_READ_LATENCY,
   parameter int SKID_DEPTH   = 8
)(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                en,
   input  logic                                fifo_empty,
   output logic                                fifo_read_en,
   input  logic [DATA_WIDTH-1:0]               fifo_data,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [DATA_WIDTH-1:0]               m_data,
   output logic [$clog2(SKID_DEPTH+1)-1:0]     inflight,
   output logic [$clog2(SKID_DEPTH+1)-1:0]     occupancy,
   output logic                                overflow_err
);

   localparam int            CW      = count_width(SKID_DEPTH);
   localparam logic [CW:0]   C_DEPTH = (CW + 1)'(SKID_DEPTH);

   logic [READ_LATENCY-1:0] r_lat;
   logic [CW-1:0]           r_inflight;
   logic [CW-1:0]           w_occupancy;
   logic                    w_credit_ok;
   logic                    w_issue;
   logic                    w_capture;

   // Reserve a buffer slot for every read still travelling through the FIFO.
   assign w_credit_ok = ({1'b0, w_occupancy} + {1'b0, r_inflight}) < C_DEPTH;
   assign w_issue     = rst_n && en && !fifo_empty && w_credit_ok;
   assign w_capture   = r_lat[READ_LATENCY-1];

   generate
      if (READ_LATENCY == 1) begin : g_lat_one
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_lat <= '0;
            end else begin
               r_lat <= w_issue;
            end
         end
      end else begin : g_lat_multi
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_lat <= '0;
            end else begin
               r_lat <= {r_lat[READ_LATENCY-2:0], w_issue};
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_capture})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   drain_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_wr        (w_capture),
      .i_wr_data   (fifo_data),
      .i_rd_ready  (m_ready),
      .o_valid     (m_valid),
      .o_rd_data   (m_data),
      .o_occupancy (w_occupancy),
      .o_overflow  (overflow_err)
   );

   assign fifo_read_en = w_issue;
   assign inflight     = r_inflight;
   assign occupancy    = w_occupancy;

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
// ============================================================================
// Module   : tb_fifo_drain_ctrl
// Brief    : Directed and random checks of fifo_drain_ctrl against a
//            transaction-level model of the FIFO and the output stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_drain_ctrl;

   localparam int DW = 4;
   localparam int RL = 5;
   localparam int SD = 8;
   localparam int CW = $clog2(SD + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          fifo_empty;
   logic          fifo_read_en;
   logic [DW-1:0] fifo_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [CW-1:0] inflight;
   logic [CW-1:0] occupancy;
   logic          overflow_err;

   always #5 clk = ~clk;

   fifo_drain_ctrl #(
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL),
      .SKID_DEPTH   (SD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_read_en (fifo_read_en),
      .fifo_data    (fifo_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .inflight     (inflight),
      .occupancy    (occupancy),
      .overflow_err (overflow_err)
   );

   typedef struct {
      int            cap;
      logic [DW-1:0] w;
   } pend_t;

   logic [DW-1:0] fq[$];       // words waiting inside the FIFO
   pend_t         dq[$];       // words on their way out of the FIFO read pipe
   logic [DW-1:0] exp_q[$];    // words read and not yet delivered, oldest first
   int            iss_q[$];    // edge numbers at which reads were issued
   logic [DW-1:0] out_log[$];

   int  ecount    = 0;
   int  pops      = 0;
   int  strobes   = 0;
   int  delivered = 0;
   int  errors    = 0;
   int  checks    = 0;
   bit  model_ok  = 1'b0;

   logic          s_rd;
   logic          s_valid;
   logic [DW-1:0] s_data;
   int            s_infl;
   int            s_occ;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive at the falling edge, check 1ns later, advance the
   // model at the rising edge.
   task automatic step(input logic a_rst, input logic a_en, input logic a_ready);
      int  exp_infl;
      int  exp_occ;
      bit  xfer;
      @(negedge clk);
      rst_n      = a_rst;
      en         = a_en;
      m_ready    = a_ready;
      fifo_empty = (fq.size() == 0);
      while (dq.size() > 0 && dq[0].cap < ecount + 1) void'(dq.pop_front());
      if (dq.size() > 0 && dq[0].cap == ecount + 1) begin
         fifo_data = dq[0].w;
         void'(dq.pop_front());
      end else begin
         fifo_data = DW'($urandom);
      end
      #1;
      exp_infl = 0;
      foreach (iss_q[i]) if (ecount - iss_q[i] < RL) exp_infl++;
      exp_occ = iss_q.size() - exp_infl - pops;
      if (model_ok || !a_rst) begin
         check("read_en", 32'(fifo_read_en),
               32'(a_rst && a_en && !fifo_empty && (exp_occ + exp_infl < SD)));
      end
      if (model_ok) begin
         check("inflight", 32'(inflight), 32'(exp_infl));
         check("occupancy", 32'(occupancy), 32'(exp_occ));
         check("m_valid", 32'(m_valid), 32'(exp_occ != 0));
         check("overflow_err", 32'(overflow_err), 32'(0));
         check("credit_bound", 32'(32'(occupancy) + 32'(inflight) <= SD), 32'(1));
         if (exp_occ > 0 && exp_q.size() > 0) begin
            check("m_data", 32'(m_data), 32'(exp_q[0]));
         end
      end
      s_rd    = fifo_read_en;
      s_valid = m_valid;
      s_data  = m_data;
      s_infl  = int'(inflight);
      s_occ   = int'(occupancy);
      xfer    = (exp_occ > 0) && a_ready && a_rst;
      @(posedge clk);
      ecount++;
      if (!a_rst) begin
         iss_q.delete();
         exp_q.delete();
         pops     = 0;
         model_ok = 1'b1;
      end else begin
         if (s_rd && fq.size() > 0) begin
            pend_t p;
            p.w   = fq.pop_front();
            p.cap = ecount + RL;
            dq.push_back(p);
            exp_q.push_back(p.w);
            iss_q.push_back(ecount);
            strobes++;
         end
         if (xfer) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pops++;
            delivered++;
            out_log.push_back(s_data);
         end
      end
   endtask

   initial begin
      int base_s;
      int base_d;
      int n_strobe;
      int n_valid;
      int peak;
      int first_x;
      int last_x;
      int pushed;
      int vcount;
      bit done;
      logic [DW-1:0] t1_words [3];

      rst_n     = 1'b0;
      en        = 1'b0;
      m_ready   = 1'b0;
      fifo_data = '0;
      fifo_empty = 1'b1;

      // Reset while the FIFO already holds data.
      t1_words = '{4'd3, 4'd7, 4'd2};
      foreach (t1_words[i]) fq.push_back(t1_words[i]);
      repeat (3) step(1'b0, 1'b1, 1'b1);
      out_log.delete();
      step(1'b1, 1'b1, 1'b1);
      check("t1_valid_after_reset", 32'(s_valid), 32'(0));
      check("t1_occ_after_reset", 32'(s_occ), 32'(0));
      repeat (15) step(1'b1, 1'b1, 1'b1);
      check("t1_delivered", 32'(out_log.size()), 32'(3));
      foreach (t1_words[i]) if (i < out_log.size()) check("t1_word", 32'(out_log[i]), 32'(t1_words[i]));

      // Streaming with the consumer always ready.
      out_log.delete();
      for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
      n_strobe = -1; n_valid = -1; peak = 0; first_x = -1; last_x = -1;
      for (int c = 0; c < 40; c++) begin
         step(1'b1, 1'b1, 1'b1);
         if (s_rd && n_strobe < 0) n_strobe = c;
         if (s_valid && n_valid < 0) n_valid = c;
         if (s_infl > peak) peak = s_infl;
         if (s_valid) begin
            if (first_x < 0) first_x = c;
            last_x = c;
         end
      end
      check("t2_first_valid_latency", 32'(n_valid - n_strobe), 32'(6));
      check("t2_inflight_peak", 32'(peak), 32'(5));
      check("t2_back_to_back", 32'(last_x - first_x), 32'(7));
      check("t2_delivered", 32'(out_log.size()), 32'(8));
      foreach (out_log[i]) check("t2_word", 32'(out_log[i]), 32'(i + 1));

      // Consumer stalled: credit must stop the strobes at the buffer depth.
      out_log.delete();
      base_s = strobes;
      for (int i = 1; i <= 10; i++) fq.push_back(DW'(i));
      repeat (25) step(1'b1, 1'b1, 1'b0);
      check("t3_strobes", 32'(strobes - base_s), 32'(8));
      check("t3_occupancy", 32'(s_occ), 32'(8));
      check("t3_head", 32'(s_data), 32'(1));
      check("t3_read_en_held", 32'(s_rd), 32'(0));
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         step(1'b1, 1'b1, 1'b1);
         if (out_log.size() >= 10) done = 1'b1;
      end
      check("t3_drain_timeout", 32'(done), 32'(1));
      foreach (out_log[i]) check("t3_word", 32'(out_log[i]), 32'(i + 1));

      // Enable withdrawn two cycles after the first strobe.
      base_s = strobes;
      base_d = delivered;
      for (int i = 9; i <= 13; i++) fq.push_back(DW'(i));
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         step(1'b1, 1'b1, 1'b1);
         if (s_rd) done = 1'b1;
      end
      check("t4_first_strobe", 32'(done), 32'(1));
      step(1'b1, 1'b1, 1'b1);
      repeat (15) step(1'b1, 1'b0, 1'b1);
      check("t4_strobes", 32'(strobes - base_s), 32'(2));
      check("t4_delivered", 32'(delivered - base_d), 32'(2));
      check("t4_inflight_zero", 32'(s_infl), 32'(0));
      fq.delete();

      // Random back-pressure with a sometimes-empty FIFO.
      base_d = delivered;
      pushed = 0;
      done   = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         if (pushed < 200 && ($urandom % 3) != 0) begin
            fq.push_back(DW'($urandom));
            pushed++;
         end
         step(1'b1, 1'b1, 1'($urandom % 2));
         if (delivered - base_d >= 200) done = 1'b1;
      end
      check("t5_all_delivered", 32'(done), 32'(1));
      check("t5_overflow", 32'(overflow_err), 32'(0));

      // Reset pulse while three reads are still in flight.
      fq.delete();
      for (int i = 1; i <= 8; i++) fq.push_back(DW'(i + 4));
      repeat (3) step(1'b1, 1'b0, 1'b0);
      base_s = strobes;
      for (int c = 0; c < 10 && (strobes - base_s) < 3; c++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("t6_inflight_at_reset", 32'(s_infl), 32'(3));
      vcount = 0;
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 1'b0, 1'b1);
         if (s_valid) vcount++;
      end
      check("t6_no_spurious_valid", 32'(vcount), 32'(0));
      check("t6_occ_after", 32'(s_occ), 32'(0));
      check("t6_inflight_after", 32'(s_infl), 32'(0));
      base_d = delivered;
      repeat (30) step(1'b1, 1'b1, 1'b1);
      check("t6_recovery", 32'(delivered - base_d), 32'(5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
